// File: rtl/candidate_selector.sv
// -----------------------------------------------------------------------------
// candidate_selector
//
// Scans the first N entries of the candidate memory bank and reports the entry
// with the highest Q-value. The result is the next-hop / cluster-head choice
// consumed by the routing FSM.
//
// Each bank entry is a 16-bit word {node_id[7:0], q_value[7:0]} located at an
// even byte index (0, 2, ..., 14). One entry is evaluated per clock cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle scan request, honoured only when idle
//   cand_count  number of entries to scan (sampled with start, clamped to 8)
//   mem_index   byte index driven to the bank (always even, registered)
//   mem_wr_en   bank write enable, constant 0 (selector only reads)
//   mem_data    bank read data, combinational from mem_index
//   busy        high while entries are being scanned
//   done        one-cycle pulse when the result is valid
//   found       1 when at least one entry was scanned
//   best_id     node_id of the winning entry
//   best_q      q_value of the winning entry
//   best_slot   entry number (0..7) of the winning entry
// -----------------------------------------------------------------------------
module candidate_selector #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_CAND   = 8,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            cand_count,
    output logic [IDX_WIDTH-1:0]  mem_index,
    output logic                  mem_wr_en,
    input  logic [WORD_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [7:0]            best_id,
    output logic [7:0]            best_q,
    output logic [2:0]            best_slot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [3:0]             count_reg;      // latched, clamped entry count
    logic [2:0]             slot_reg;       // entry currently being evaluated
    logic [IDX_WIDTH-1:0]   mem_index_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   found_reg;
    logic [7:0]             best_id_reg;
    logic [7:0]             best_q_reg;
    logic [2:0]             best_slot_reg;

    logic [3:0]             clamped_count;
    logic                   last_slot;
    logic [7:0]             cur_id;
    logic [7:0]             cur_q;
    logic                   take_entry;

    // Requests above the bank capacity scan the whole bank.
    assign clamped_count = (cand_count > 4'(MAX_CAND)) ? 4'(MAX_CAND) : cand_count;

    // count_reg is at least 1 whenever this is consulted in SCAN.
    assign last_slot = ({1'b0, slot_reg} == (count_reg - 4'd1));

    assign cur_id = mem_data[WORD_WIDTH-1 -: 8];
    assign cur_q  = mem_data[7:0];

    // Slot 0 seeds the running best; later slots must be strictly greater,
    // so on a tie the lowest slot is kept.
    assign take_entry = (slot_reg == 3'd0) || (cur_q > best_q_reg);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (clamped_count == 4'd0) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (last_slot) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 4'd0;
            slot_reg      <= 3'd0;
            mem_index_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            found_reg     <= 1'b0;
            best_id_reg   <= 8'd0;
            best_q_reg    <= 8'd0;
            best_slot_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            // Status flags are registered from the upcoming state so they line
            // up exactly with the cycle spent in that state.
            busy_reg  <= (state_next == SCAN);
            done_reg  <= (state_next == FIN);

            case (state_reg)
                IDLE: begin
                    mem_index_reg <= '0;
                    if (start) begin
                        count_reg     <= clamped_count;
                        slot_reg      <= 3'd0;
                        found_reg     <= 1'b0;
                        best_id_reg   <= 8'd0;
                        best_q_reg    <= 8'd0;
                        best_slot_reg <= 3'd0;
                    end
                end
                SCAN: begin
                    if (take_entry) begin
                        best_id_reg   <= cur_id;
                        best_q_reg    <= cur_q;
                        best_slot_reg <= slot_reg;
                    end
                    found_reg <= 1'b1;
                    if (last_slot) begin
                        mem_index_reg <= '0;
                    end else begin
                        slot_reg      <= slot_reg + 3'd1;
                        mem_index_reg <= mem_index_reg + IDX_WIDTH'(2);
                    end
                end
                FIN: begin
                    mem_index_reg <= '0;
                end
                default: begin
                    mem_index_reg <= '0;
                end
            endcase
        end
    end

    assign mem_index = mem_index_reg;
    assign mem_wr_en = 1'b0;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign found     = found_reg;
    assign best_id   = best_id_reg;
    assign best_q    = best_q_reg;
    assign best_slot = best_slot_reg;

endmodule

// File: tb/tb_candidate_selector.sv
// -----------------------------------------------------------------------------
// tb_candidate_selector
//
// Self-checking bench for candidate_selector. The bank is modelled as an array
// read combinationally by mem_index. Expected results come from a reference
// that finds the maximum Q-value over the scanned entries and then the lowest
// slot holding that value.
// -----------------------------------------------------------------------------
module tb_candidate_selector;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cand_count;
    logic [3:0]  mem_index;
    logic        mem_wr_en;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [7:0]  best_id;
    logic [7:0]  best_q;
    logic [2:0]  best_slot;

    logic [15:0] bank [8];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference result
    logic        exp_found;
    logic [7:0]  exp_id;
    logic [7:0]  exp_q;
    logic [2:0]  exp_slot;

    assign mem_data = bank[mem_index[3:1]];

    candidate_selector #(
        .WORD_WIDTH (16),
        .MAX_CAND   (8),
        .IDX_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cand_count (cand_count),
        .mem_index  (mem_index),
        .mem_wr_en  (mem_wr_en),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_id    (best_id),
        .best_q     (best_q),
        .best_slot  (best_slot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Highest Q over entries 0..n-1; ties resolved to the lowest slot.
    task automatic model(input int n);
        int  max_q;
        bit  hit;
        exp_found = (n > 0);
        exp_id    = 8'd0;
        exp_q     = 8'd0;
        exp_slot  = 3'd0;
        if (n > 0) begin
            max_q = 0;
            for (int i = 0; i < n; i++) begin
                if (int'(bank[i][7:0]) > max_q) max_q = int'(bank[i][7:0]);
            end
            hit = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!hit && int'(bank[i][7:0]) == max_q) begin
                    exp_id   = bank[i][15:8];
                    exp_q    = bank[i][7:0];
                    exp_slot = 3'(i);
                    hit      = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_index"}, 32'(mem_index), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_found"},     32'(found),     32'd0);
        chk({tag, "_best_id"},   32'(best_id),   32'd0);
        chk({tag, "_best_q"},    32'(best_q),    32'd0);
        chk({tag, "_best_slot"}, 32'(best_slot), 32'd0);
    endtask

    // Full scan with per-cycle checks. repulse_at: SCAN cycle in which start is
    // re-pulsed (0 = never). mutate: rewrite the last entry during cycle 1,
    // before that entry is read.
    task automatic run_scan(input string tag, input logic [3:0] cnt,
                            input int repulse_at, input bit mutate);
        int n;
        n = (cnt > 4'd8) ? 8 : int'(cnt);
        @(negedge clk);
        start      = 1'b1;
        cand_count = cnt;
        @(negedge clk);
        start      = 1'b0;
        cand_count = 4'($urandom_range(0, 15));
        for (int c = 1; c <= n; c++) begin
            chk({tag, "_mem_index"}, 32'(mem_index), 32'(2 * (c - 1)));
            chk({tag, "_busy"},      32'(busy),      32'd1);
            chk({tag, "_done_early"}, 32'(done),     32'd0);
            chk({tag, "_wr_en"},     32'(mem_wr_en), 32'd0);
            if (mutate && c == 1 && n > 1) bank[n-1] = 16'hEEFF;
            if (c == repulse_at) begin
                start      = 1'b1;
                cand_count = 4'd1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        model(n);
        chk({tag, "_done"},      32'(done),      32'd1);
        chk({tag, "_busy_fin"},  32'(busy),      32'd0);
        chk({tag, "_found"},     32'(found),     32'(exp_found));
        chk({tag, "_best_id"},   32'(best_id),   32'(exp_id));
        chk({tag, "_best_q"},    32'(best_q),    32'(exp_q));
        chk({tag, "_best_slot"}, 32'(best_slot), 32'(exp_slot));
        $display("txn %s: count=%0d id=0x%02h q=0x%02h slot=%0d found=%0d",
                 tag, cnt, best_id, best_q, best_slot, found);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done),    32'd0);
        chk({tag, "_hold_id"},   32'(best_id),  32'(exp_id));
        chk({tag, "_hold_slot"}, 32'(best_slot), 32'(exp_slot));
        chk({tag, "_idle_idx"},  32'(mem_index), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cand_count = 4'd0;
        for (int i = 0; i < 8; i++) bank[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // Basic three-entry scan
        bank[0] = 16'h1120; bank[1] = 16'h2255; bank[2] = 16'h3340;
        run_scan("basic3", 4'd3, 0, 1'b0);

        // Tie resolves to the lowest slot
        bank[0] = 16'h0A7F; bank[1] = 16'h0B7F;
        run_scan("tie", 4'd2, 0, 1'b0);

        // Empty scan
        run_scan("zero", 4'd0, 0, 1'b0);

        // Count above capacity, maximum in the last slot
        for (int i = 0; i < 7; i++) bank[i] = {8'(8'h10 + i), 8'(8'h30 + 8 * i)};
        bank[7] = 16'h88F0;
        run_scan("clamp12", 4'd12, 0, 1'b0);

        // start re-pulsed mid-scan is ignored
        bank[0] = 16'h0110; bank[1] = 16'h0260; bank[2] = 16'h0320;
        bank[3] = 16'h0460; bank[4] = 16'h0550;
        run_scan("repulse", 4'd5, 2, 1'b0);

        // Entry rewritten before it is read is used as rewritten
        run_scan("mutate", 4'd4, 0, 1'b1);

        // Reset pulsed at slot 2 of a second run
        @(negedge clk);
        start      = 1'b1;
        cand_count = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_slot2_idx", 32'(mem_index), 32'd4);
        rst = 1'b1;
        #1;
        chk_all_zero("abort_now");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_zero("abort_hold");
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_no_busy", 32'(busy), 32'd0);
        end
        $display("txn abort: reset at slot 2, outputs cleared");

        // Randomised scans; narrow Q range on some runs to provoke ties
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 8; i++) begin
                bank[i][15:8] = 8'($urandom_range(0, 255));
                bank[i][7:0]  = (r % 2 == 0) ? 8'($urandom_range(0, 3))
                                             : 8'($urandom_range(0, 255));
            end
            run_scan("rand", 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/candidate_selector.md
Name: candidate_selector

Overview:
- Downstream consumer of the candidate memory bank.
- The bank holds up to 8 candidate entries, each a 16-bit word = {node_id[7:0], q_value[7:0]}, stored at even byte indices 0,2,...,14.
- On start, the selector scans the first cand_count entries through the bank's read port and reports the node with the highest Q-value. The result is the next-hop / cluster-head choice for the routing FSM.

Parameters:
- WORD_WIDTH, 16, width of a candidate entry (node_id in [15:8], q_value in [7:0]).
- MAX_CAND, 8, maximum number of candidate entries in the bank.
- IDX_WIDTH, 4, width of the bank byte index.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- cand_count  in  4  number of valid entries to scan; sampled with start; values >8 are clamped to 8.
- mem_index  out  IDX_WIDTH  byte index driven to the bank; always even.
- mem_wr_en  out  1  bank write enable; tied 0 (selector is read-only).
- mem_data  in  WORD_WIDTH  bank read data, combinational from mem_index.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  1 if at least one entry was scanned.
- best_id  out  8  node_id of the winning entry.
- best_q  out  8  q_value of the winning entry.
- best_slot  out  3  entry number (0..7) of the winner.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_index, busy, done, found, best_id, best_q, best_slot all 0.
  - Internal count and slot counters 0.
- States:
  - IDLE -> SCAN on start with clamped count N>0.
  - IDLE -> FIN on start with N=0.
  - SCAN -> FIN after slot N-1 is evaluated.
  - FIN -> IDLE unconditionally.
- IDLE:
  - mem_index=0, busy=0.
  - On start: latch N, clear the running best (best_q=0, best_id=0, best_slot=0), clear found, set slot k=0.
- SCAN (one entry per cycle):
  - mem_index = 2*k, registered so it is stable for the whole cycle.
  - At the clock edge, compare mem_data[7:0] with the running best_q.
  - Slot 0 always loads unconditionally.
  - A later slot replaces the best only if strictly greater (unsigned). Ties keep the lowest slot.
  - found=1 after slot 0 is taken.
  - k increments; after the slot N-1 edge, go to FIN.
- FIN:
  - done=1 for exactly this cycle, busy=0.
  - Outputs best_id, best_q, best_slot and found are valid and held unchanged until the next accepted start.
- Latency: start edge -> done high in cycle N+1 (N SCAN cycles + 1 FIN cycle); N=0 gives done in the cycle right after start.
- start while busy or in FIN: ignored, no restart, no effect on counters.
- Bank contents changing mid-scan: each slot uses the data present in its own SCAN cycle; no snapshot.
- Reset mid-scan: abort immediately, all outputs 0, no done pulse.
- mem_index never exceeds 14; index+1 for the bank stays ≤15.

Test Plan:
- Reset then idle: assert rst for 3 cycles mid-run -> all outputs 0, mem_index=0, done never pulses.
- Bank entries {0x11,0x20},{0x22,0x55},{0x33,0x40}, cand_count=3, start -> mem_index 0,2,4 on consecutive cycles; done in cycle 4 with best_id=0x22, best_q=0x55, best_slot=1, found=1.
- Tie: entries {0x0A,0x7F},{0x0B,0x7F}, count=2 -> best_id=0x0A, best_slot=0 (lowest slot wins).
- cand_count=0 -> done the cycle after start, found=0, best_id=0, best_q=0, no SCAN cycles.
- cand_count=12 with all 8 entries filled, max {0x88,0xF0} at slot 7 -> clamped to 8; last mem_index=14; best_slot=7, best_id=0x88; done in cycle 9.
- start re-pulsed during a 5-entry scan, and rst pulsed in a second run at slot 2 -> the first run still completes in cycle 6 with the original result; the second run aborts with outputs 0 and no done.
